// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle_bank channel bank: edge-select encodings
// and the helper that decides whether an accepted level change qualifies.
package toggle_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_NONE = 2'b00;
    localparam logic [MODE_W-1:0] MODE_RISE = 2'b01;
    localparam logic [MODE_W-1:0] MODE_FALL = 2'b10;
    localparam logic [MODE_W-1:0] MODE_BOTH = 2'b11;

    // A new level of 1 is a rising edge, 0 a falling edge.
    function automatic logic edge_qualifies(input logic [MODE_W-1:0] mode,
                                            input logic              new_lvl);
        logic [MODE_W-1:0] sel;
        sel = new_lvl ? MODE_RISE : MODE_FALL;
        return (mode & sel) != '0;
    endfunction

endpackage

// File: rtl/toggle_ch.sv
// One toggle_bank channel: 2-flop synchroniser, debounce, edge qualify, toggle.
// Long-press detection is built only when TOGGLE_BANK_HOLD_EN is defined.
module toggle_ch
    import toggle_pkg::*;
#(
    parameter int unsigned DB_CNT   = 16,
    parameter logic        IDLE_LVL = 1'b1,
    parameter int unsigned HOLD_CNT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              clr_i,
    output logic              stable_o,
    output logic              edge_pulse_o,
    output logic              out_o,
    output logic              hold_pulse_o
);

    localparam int unsigned CNT_W = $clog2(DB_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    logic [1:0]       sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_q, edge_d;
    logic             out_q, out_d;
    logic             raw;

    assign raw = sync_q[1];

    // Debounce, edge qualification and toggle.
    always_comb begin
        sync_d   = {sync_q[0], in_i};
        stable_d = stable_q;
        cnt_d    = '0;
        edge_d   = 1'b0;
        out_d    = out_q;
        if (raw != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = raw;
                if (edge_qualifies(mode_i, raw)) begin
                    edge_d = 1'b1;
                    out_d  = ~out_q;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (clr_i) begin
            out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= {2{IDLE_LVL}};
            stable_q <= IDLE_LVL;
            cnt_q    <= '0;
            edge_q   <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            out_q    <= out_d;
        end
    end

    assign stable_o     = stable_q;
    assign edge_pulse_o = edge_q;
    assign out_o        = out_q;

`ifdef TOGGLE_BANK_HOLD_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CNT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CNT);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              hold_pulse_q, hold_pulse_d;

    // Saturating press-duration counter; pulses once when it reaches the threshold.
    always_comb begin
        hold_d       = '0;
        hold_pulse_d = 1'b0;
        if (stable_q != IDLE_LVL) begin
            hold_d = hold_q;
            if (hold_q != HOLD_MAX) begin
                hold_d       = hold_q + HOLD_W'(1);
                hold_pulse_d = (hold_q == HOLD_MAX - HOLD_W'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q       <= '0;
            hold_pulse_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_pulse_q <= hold_pulse_d;
        end
    end

    assign hold_pulse_o = hold_pulse_q;
`else
    logic unused_hold_cfg;
    assign unused_hold_cfg = ^32'(HOLD_CNT);
    assign hold_pulse_o    = 1'b0;
`endif

endmodule

// File: rtl/toggle_bank.sv
// Multi-channel debounced edge-toggle bank; one toggle_ch per input pin.
// Optional long-press pulses are enabled with TOGGLE_BANK_HOLD_EN.
module toggle_bank #(
    parameter int unsigned    CH       = 4,
    parameter int unsigned    DB_CNT   = 16,
    parameter logic [CH-1:0]  IDLE_LVL = {CH{1'b1}},
    parameter int unsigned    HOLD_CNT = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   in,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   clr,
    output logic [CH-1:0]   stable,
    output logic [CH-1:0]   edgePulse,
    output logic [CH-1:0]   out,
    output logic [CH-1:0]   holdPulse
);

    for (genvar i = 0; i < int'(CH); i++) begin : g_ch
        toggle_ch #(
            .DB_CNT   (DB_CNT),
            .IDLE_LVL (IDLE_LVL[i]),
            .HOLD_CNT (HOLD_CNT)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .in_i         (in[i]),
            .mode_i       (mode[2*i +: 2]),
            .clr_i        (clr[i]),
            .stable_o     (stable[i]),
            .edge_pulse_o (edgePulse[i]),
            .out_o        (out[i]),
            .hold_pulse_o (holdPulse[i])
        );
    end

endmodule

// File: tb/tb_toggle_bank.sv
// Scoreboard bench for toggle_bank (CH=4, DB_CNT=4, HOLD_CNT=10).
// Define TOGGLE_BANK_HOLD_EN to also expect long-press pulses.
module tb_toggle_bank;
    import toggle_pkg::*;

    localparam int unsigned CH   = 4;
    localparam int unsigned DB   = 4;
    localparam int unsigned HOLD = 10;
    // Inputs are driven 1 time unit after edge N, sampled at N+1, accepted at N+2+DB.
    localparam int LAT = int'(DB) + 2;

`ifdef TOGGLE_BANK_HOLD_EN
    localparam logic [3:0] HP_ALL = 4'hF;
`else
    localparam logic [3:0] HP_ALL = 4'h0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] in, clr, stable, edgePulse, out, holdPulse;
    logic [7:0]    mode;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] st, ep, ot, hp;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    toggle_bank #(
        .CH       (CH),
        .DB_CNT   (DB),
        .IDLE_LVL (4'hF),
        .HOLD_CNT (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .mode      (mode),
        .clr       (clr),
        .stable    (stable),
        .edgePulse (edgePulse),
        .out       (out),
        .holdPulse (holdPulse)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic expect_at(input string tag, input int dly, input logic [3:0] st,
                             input logic [3:0] ep, input logic [3:0] ot,
                             input logic [3:0] hp = 4'h0);
        exp_t e;
        e.cyc = cyc + dly;
        e.tag = tag;
        e.st  = st;
        e.ep  = ep;
        e.ot  = ot;
        e.hp  = hp;
        sb.push_back(e);
    endtask

    // Advance one clock per iteration and retire every expectation due now.
    task automatic step(input int n = 1);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check_val({e.tag, "_when"}, 32'(cyc), 32'(e.cyc));
                check_val({e.tag, "_stable"}, 32'(stable), 32'(e.st));
                check_val({e.tag, "_edge"}, 32'(edgePulse), 32'(e.ep));
                check_val({e.tag, "_out"}, 32'(out), 32'(e.ot));
                check_val({e.tag, "_hold"}, 32'(holdPulse), 32'(e.hp));
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        in   = 4'hF;
        mode = 8'h00;
        clr  = 4'h0;
        step(2);
        check_val("rst_stable", 32'(stable), 32'h0000_000F);
        check_val("rst_edge", 32'(edgePulse), 32'h0);
        check_val("rst_out", 32'(out), 32'h0);
        check_val("rst_hold", 32'(holdPulse), 32'h0);
        rst = 1'b0;
        step(2);

        // ch0 falling edge, fixed latency
        mode = {6'b0, MODE_FALL};
        in   = 4'hE;
        expect_at("f0_pre", LAT - 1, 4'hF, 4'h0, 4'h0);
        expect_at("f0_acc", LAT, 4'hE, 4'h1, 4'h1);
        expect_at("f0_post", LAT + 1, 4'hE, 4'h0, 4'h1);
        step(8);
        in = 4'hF;
        expect_at("f0_rel", LAT, 4'hF, 4'h0, 4'h1);
        step(8);

        // ch0 glitch of 3 cycles is rejected
        in = 4'hE;
        for (int d = 1; d <= 10; d++) expect_at("glitch", d, 4'hF, 4'h0, 4'h1);
        step(3);
        in = 4'hF;
        step(7);
        in = 4'hE;
        expect_at("g_acc", LAT, 4'hE, 4'h1, 4'h0);
        expect_at("g_post", LAT + 1, 4'hE, 4'h0, 4'h0);
        step(8);
        in = 4'hF;
        expect_at("g_rel", LAT, 4'hF, 4'h0, 4'h0);
        step(8);

        // ch1 both edges, then none
        mode = {4'b0, MODE_BOTH, MODE_NONE};
        in   = 4'hD;
        expect_at("b_press", LAT, 4'hD, 4'h2, 4'h2);
        expect_at("b_press1", LAT + 1, 4'hD, 4'h0, 4'h2);
        step(8);
        in = 4'hF;
        expect_at("b_rel", LAT, 4'hF, 4'h2, 4'h0);
        step(8);
        mode = 8'h00;
        in   = 4'hD;
        expect_at("n_press", LAT, 4'hD, 4'h0, 4'h0);
        step(8);
        in = 4'hF;
        expect_at("n_rel", LAT, 4'hF, 4'h0, 4'h0);
        step(8);

        // ch2 clear wins over a coincident toggle
        mode = {2'b00, MODE_FALL, 4'b0};
        in   = 4'hB;
        expect_at("c_set", LAT, 4'hB, 4'h4, 4'h4);
        step(8);
        in = 4'hF;
        expect_at("c_rel", LAT, 4'hF, 4'h0, 4'h4);
        step(8);
        in = 4'hB;
        expect_at("c_clr", LAT, 4'hB, 4'h4, 4'h0);
        step(LAT - 1);
        clr = 4'h4;
        step(1);
        clr = 4'h0;
        step(2);
        in = 4'hF;
        expect_at("c_rel2", LAT, 4'hF, 4'h0, 4'h0);
        step(8);

        // all channels fall together; long hold
        mode = {MODE_FALL, MODE_FALL, MODE_FALL, MODE_FALL};
        in   = 4'h0;
        expect_at("all_pre", LAT - 1, 4'hF, 4'h0, 4'h0);
        expect_at("all_acc", LAT, 4'h0, 4'hF, 4'hF);
        expect_at("all_post", LAT + 1, 4'h0, 4'h0, 4'hF);
        expect_at("hold_pre", LAT + int'(HOLD) - 1, 4'h0, 4'h0, 4'hF, 4'h0);
        expect_at("hold_hit", LAT + int'(HOLD), 4'h0, 4'h0, 4'hF, HP_ALL);
        expect_at("hold_post", LAT + int'(HOLD) + 1, 4'h0, 4'h0, 4'hF, 4'h0);
        expect_at("hold_sat", LAT + 30, 4'h0, 4'h0, 4'hF, 4'h0);
        step(LAT + 30);
        in = 4'hF;
        expect_at("all_rel", LAT, 4'hF, 4'h0, 4'hF);
        step(8);

        // reset mid-debounce of a second press
        in = 4'h0;
        step(3);
        rst = 1'b1;
        in  = 4'hF;
        step(2);
        check_val("mid_rst_stable", 32'(stable), 32'h0000_000F);
        check_val("mid_rst_out", 32'(out), 32'h0);
        check_val("mid_rst_edge", 32'(edgePulse), 32'h0);
        rst = 1'b0;
        for (int d = 1; d <= 10; d++) expect_at("after_rst", d, 4'hF, 4'h0, 4'h0);
        step(10);

        check_val("sb_drain", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
